mod11_count_monitor: RTL and testbench

Downstream observer for the 4-bit synchronous mod-11 counter (`clk`, `rst`, `ld`, `ld_enb`, `count`). It samples the counter's `count` output every clock and classifies each transition as step, wrap, stall, jump (load/reset) or illegal value. It emits one-cycle event pulses and keeps wrap and jump statistics plus a sticky error flag. Status logic and benches use it to confirm counter sequencing without re-deriving the count sequence.

---
 rtl/mod11_count_monitor.sv | 95 +++++++++
 tb/tb_mod11_count_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mod11_count_monitor.sv
// Observer for a mod-MOD counter: classifies each sampled transition, emits
// one-cycle event pulses, and keeps wrap/jump statistics plus a sticky error flag.
module mod11_count_monitor #(
  parameter int MOD    = 11,
  parameter int WRAP_W = 8,
  parameter int JUMP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        count_in,
  input  logic              clr_stats,
  output logic              wrap_pulse,
  output logic              step_pulse,
  output logic              stall_pulse,
  output logic              jump_pulse,
  output logic              illegal_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [JUMP_W-1:0] jump_cnt,
  output logic              err_flag
);

  typedef enum logic [2:0] {
    EV_NONE,
    EV_ILLEGAL,
    EV_WRAP,
    EV_STEP,
    EV_STALL,
    EV_JUMP
  } event_e;

  // Five-bit compares let MOD reach 16 and keep prev = 15 from matching prev + 1.
  localparam logic [4:0] MOD_L  = 5'(MOD);
  localparam logic [4:0] LAST_L = 5'(MOD - 1);

  logic [3:0] prev;
  logic       prev_valid;
  event_e     ev;
  logic [4:0] cur5;
  logic [4:0] prev5;

  assign cur5  = {1'b0, count_in};
  assign prev5 = {1'b0, prev};

  // Priority chain: exactly one class fires once prev holds a real sample.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    ev = EV_NONE;
    if (prev_valid) begin
      if (cur5 >= MOD_L)                               ev = EV_ILLEGAL;
      else if (prev5 == LAST_L && cur5 == 5'd0)        ev = EV_WRAP;
      else if (cur5 == prev5 + 5'd1 && prev5 < LAST_L) ev = EV_STEP;
      else if (cur5 == prev5)                          ev = EV_STALL;
      else                                             ev = EV_JUMP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev          <= '0;
      prev_valid    <= 1'b0;
      wrap_pulse    <= 1'b0;
      step_pulse    <= 1'b0;
      stall_pulse   <= 1'b0;
      jump_pulse    <= 1'b0;
      illegal_pulse <= 1'b0;
      wrap_cnt      <= '0;
      jump_cnt      <= '0;
      err_flag      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
      prev          <= count_in;
      prev_valid    <= 1'b1;
      wrap_pulse    <= (ev == EV_WRAP);
      step_pulse    <= (ev == EV_STEP);
      stall_pulse   <= (ev == EV_STALL);
      jump_pulse    <= (ev == EV_JUMP);
      illegal_pulse <= (ev == EV_ILLEGAL);

      // Clear beats a same-cycle event on the statistics; the pulse above still fires.
      if (clr_stats) begin
        wrap_cnt <= '0;
        jump_cnt <= '0;
        err_flag <= 1'b0;
      end else begin
        if (ev == EV_WRAP)
          wrap_cnt <= wrap_cnt + WRAP_W'(1);
        if (ev == EV_JUMP && jump_cnt != {JUMP_W{1'b1}})
          jump_cnt <= jump_cnt + JUMP_W'(1);
        if (ev == EV_ILLEGAL)
          err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod11_count_monitor.sv
// Self-checking bench: directed scenarios then random counter-like traffic,
// compared each cycle against a behavioural model of the classification rules.
module tb_mod11_count_monitor;

  localparam int MOD = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count_in = 4'd0;
  logic       clr_stats = 1'b0;

  logic       wrap_pulse, step_pulse, stall_pulse, jump_pulse, illegal_pulse, err_flag;
  logic [7:0] wrap_cnt;
  logic [3:0] jump_cnt;

  logic       w2_wrap_pulse, w2_step_pulse, w2_stall_pulse, w2_jump_pulse, w2_illegal_pulse, w2_err_flag;
  logic [1:0] w2_wrap_cnt;
  logic [3:0] w2_jump_cnt;

  mod11_count_monitor dut (
    .clk(clk), .rst(rst), .count_in(count_in), .clr_stats(clr_stats),
    .wrap_pulse(wrap_pulse), .step_pulse(step_pulse), .stall_pulse(stall_pulse),
    .jump_pulse(jump_pulse), .illegal_pulse(illegal_pulse),
    .wrap_cnt(wrap_cnt), .jump_cnt(jump_cnt), .err_flag(err_flag)
  );

  mod11_count_monitor #(.MOD(11), .WRAP_W(2), .JUMP_W(4)) dut_w2 (
    .clk(clk), .rst(rst), .count_in(count_in), .clr_stats(clr_stats),
    .wrap_pulse(w2_wrap_pulse), .step_pulse(w2_step_pulse), .stall_pulse(w2_stall_pulse),
    .jump_pulse(w2_jump_pulse), .illegal_pulse(w2_illegal_pulse),
    .wrap_cnt(w2_wrap_cnt), .jump_cnt(w2_jump_cnt), .err_flag(w2_err_flag)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  // Reference model state: unbounded statistics, reduced at comparison time.
  int m_prev  = 0;
  bit m_valid = 1'b0;
  int m_wraps = 0;
  int m_jumps = 0;
  bit m_err   = 1'b0;
  int m_class = 0;   // 0 none, 1 illegal, 2 wrap, 3 step, 4 stall, 5 jump
  int step_seen  = 0;
  int stall_seen = 0;
  int other_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int classify(input int p, input int c);
    if (c >= MOD)                 return 1;
    if (p == MOD - 1 && c == 0)   return 2;
    if (c == p + 1 && p < MOD - 1) return 3;
    if (c == p)                   return 4;
    return 5;
  endfunction

  // One clock: drive at negedge, advance the model at posedge, compare after it.
  task automatic tick(input int c, input bit clr = 1'b0, input bit r = 1'b0);
    int jsat;
    @(negedge clk);
    count_in  = 4'(c);
    clr_stats = clr;
    rst       = r;
    @(posedge clk);
    if (r) begin
      m_prev = 0; m_valid = 1'b0; m_class = 0;
      m_wraps = 0; m_jumps = 0; m_err = 1'b0;
    end else begin
      m_class = m_valid ? classify(m_prev, c) : 0;
      if (clr) begin
        m_wraps = 0; m_jumps = 0; m_err = 1'b0;
      end else begin
        if (m_class == 2) m_wraps++;
        if (m_class == 5) m_jumps++;
        if (m_class == 1) m_err = 1'b1;
      end
      m_prev  = c;
      m_valid = 1'b1;
    end
    #1;
    jsat = (m_jumps > 15) ? 15 : m_jumps;
    check("wrap_pulse",    32'(wrap_pulse),    32'(m_class == 2));
    check("step_pulse",    32'(step_pulse),    32'(m_class == 3));
    check("stall_pulse",   32'(stall_pulse),   32'(m_class == 4));
    check("jump_pulse",    32'(jump_pulse),    32'(m_class == 5));
    check("illegal_pulse", 32'(illegal_pulse), 32'(m_class == 1));
    check("wrap_cnt",      32'(wrap_cnt),      32'(m_wraps % 256));
    check("jump_cnt",      32'(jump_cnt),      32'(jsat));
    check("err_flag",      32'(err_flag),      32'(m_err));
    check("w2_wrap_pulse", 32'(w2_wrap_pulse), 32'(m_class == 2));
    check("w2_wrap_cnt",   32'(w2_wrap_cnt),   32'(m_wraps % 4));
    check("w2_jump_cnt",   32'(w2_jump_cnt),   32'(jsat));
    if (step_pulse)  step_seen++;
    if (stall_pulse) stall_seen++;
    if (wrap_pulse || jump_pulse || illegal_pulse || step_pulse) other_seen++;
  endtask

  initial begin
    int cur;
    int r;

    // Reset state.
    tick(0, 1'b0, 1'b1);
    check("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);

    // Free run 0..10,0: ten steps and one wrap.
    step_seen = 0;
    for (int i = 0; i <= 10; i++) tick(i);
    tick(0);
    check("free_steps",    32'(step_seen),  32'd10);
    check("free_wrap",     32'(wrap_pulse), 32'd1);
    check("free_wrap_cnt", 32'(wrap_cnt),   32'd1);

    // Load while counting: 7 -> 3 is one jump, then 17 more saturate at 15.
    for (int i = 1; i <= 7; i++) tick(i);
    tick(3);
    check("load_jump",     32'(jump_pulse), 32'd1);
    check("load_jump_cnt", 32'(jump_cnt),   32'd1);
    for (int i = 0; i < 17; i++) tick((i % 2 == 0) ? 9 : 3);
    check("jump_sat", 32'(jump_cnt), 32'd15);

    // Illegal value: 12 flags, 12 -> 0 is a jump, error sticks until clear.
    tick(12);
    check("illegal_pulse_12", 32'(illegal_pulse), 32'd1);
    tick(0);
    check("illegal_then_jump", 32'(jump_pulse), 32'd1);
    for (int i = 1; i <= 3; i++) tick(i);
    check("err_sticky", 32'(err_flag), 32'd1);
    tick(4, 1'b1);
    check("err_cleared", 32'(err_flag), 32'd0);

    // Stall: holding 5 for three samples gives two stalls and nothing else.
    tick(5);
    stall_seen = 0; other_seen = 0;
    tick(5);
    tick(5);
    check("stall_count", 32'(stall_seen), 32'd2);
    check("stall_clean", 32'(other_seen), 32'd0);

    // 2-bit wrap counter overflow, then clear colliding with the 6th wrap.
    tick(9, 1'b1);
    for (int w = 0; w < 5; w++) begin
      tick(10);
      tick(0);
      if (w < 4) tick(9);
    end
    check("w2_overflow", 32'(w2_wrap_cnt), 32'd1);
    tick(9);
    tick(10);
    tick(0, 1'b1);
    check("clr_collide_pulse", 32'(w2_wrap_pulse), 32'd1);
    check("clr_collide_cnt",   32'(w2_wrap_cnt),   32'd0);

    // Reset mid-operation: first sample after release only primes.
    tick(8);
    tick(8, 1'b0, 1'b1);
    tick(0);
    check("post_rst_quiet", 32'(jump_pulse | step_pulse | wrap_pulse | illegal_pulse | stall_pulse), 32'd0);
    check("post_rst_jumps", 32'(jump_cnt), 32'd0);
    tick(1);
    check("post_rst_step", 32'(step_pulse), 32'd1);

    // Counter-only reset to 0 from the top value counts as a wrap, from elsewhere as a jump.
    for (int i = 2; i <= 10; i++) tick(i);
    tick(0);
    check("ctr_rst_wrap", 32'(wrap_pulse), 32'd1);
    tick(6);
    tick(0);
    check("ctr_rst_jump", 32'(jump_pulse), 32'd1);

    // Random counter-like traffic with occasional loads, stalls, illegal values.
    cur = 0;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65)      cur = (cur + 1) % MOD;
      else if (r < 75) cur = cur;
      else if (r < 85) cur = int'($urandom_range(0, MOD - 1));
      else if (r < 92) cur = int'($urandom_range(0, 15));
      else if (r < 96) cur = (cur == 15) ? 0 : cur;
      else             cur = MOD - 1;
      tick(cur, ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
